stable_value_scheduler: RTL and testbench

STABLE_VALUE_SCHEDULER -- requirements
Module: stable_value_scheduler

---
 rtl/stable_value_pkg.sv | 24 ++
 rtl/stable_value_rr_arbiter.sv | 35 +++
 rtl/stable_value_scheduler.sv | 176 +++++++++++++++++
 tb/tb_stable_value_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stable_value_pkg.sv
// Shared encodings and the width helper used by the stable-value scheduler and its arbiter.
package stable_value_pkg;

  typedef enum logic [1:0] {
    UNSTABLE      = 2'b00,
    PENDING       = 2'b01,
    WAIT_UNSTABLE = 2'b11
  } ch_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stable_value_rr_arbiter.sv
// Round-robin pick among requesting channels, starting just after the last grant.
// Purely combinational; zero latency, no backpressure of its own.
module stable_value_rr_arbiter
  import stable_value_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]        i_req_mask,
  input  logic [clog2(CHANNELS)-1:0] i_last_grant,
  output logic [clog2(CHANNELS)-1:0] o_grant,
  output logic                       o_any_request
);

  localparam int IW = clog2(CHANNELS);

  int            w_idx;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_grant       = '0;
    o_any_request = 1'b0;
    w_idx         = 0;
    w_pos         = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      w_idx = int'(i_last_grant) + i;
      if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
      w_pos = IW'(w_idx);
      if (!o_any_request && i_req_mask[w_pos]) begin
        o_any_request = 1'b1;
        o_grant       = w_pos;
      end
    end
  end

endmodule

// File: rtl/stable_value_scheduler.sv
// Debounces CHANNELS raw inputs (4 equal samples, one sample per channel per tick) and reports
// each newly stable value once through a valid/ready event port that holds while not ready.
module stable_value_scheduler
  import stable_value_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int DIVIDER  = 1000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [CHANNELS*WIDTH-1:0]   rawValues,
  output logic                        eventValid,
  output logic [clog2(CHANNELS)-1:0]  eventChannel,
  output logic [WIDTH-1:0]            eventValue,
  input  logic                        eventReady,
  output logic [CHANNELS-1:0]         stableMask
);

  localparam int IW = clog2(CHANNELS);
  localparam int PW = clog2(DIVIDER);

  if (DIVIDER <= CHANNELS || CHANNELS < 2 || CHANNELS > 16) begin : g_param_check
    $error("stable_value_scheduler: requires 2 <= CHANNELS <= 16 and DIVIDER > CHANNELS");
  end

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  scan_state_t      r_scan_state;
  logic [IW-1:0]    r_scan_idx;

  ch_state_t        r_ch_state [CHANNELS];
  logic [WIDTH-1:0] r_h1       [CHANNELS];
  logic [WIDTH-1:0] r_h2       [CHANNELS];
  logic [WIDTH-1:0] r_h3       [CHANNELS];
  logic [WIDTH-1:0] r_stable   [CHANNELS];
  logic [1:0]       r_fill     [CHANNELS];

  logic             r_evt_vld;
  logic [IW-1:0]    r_evt_ch;
  logic [WIDTH-1:0] r_evt_val;
  logic [IW-1:0]    r_last_grant;

  logic                w_visit;
  logic [WIDTH-1:0]    w_raw;
  logic                w_hist_eq;
  logic                w_accept;
  logic [CHANNELS-1:0] w_pending;
  logic [IW-1:0]       w_grant;
  logic                w_any_req;

  assign w_tick   = (r_presc == PW'(DIVIDER - 1));
  assign w_visit  = (r_scan_state == SCAN);
  assign w_accept = r_evt_vld && eventReady;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_state <= IDLE;
      r_scan_idx   <= '0;
    end else begin
      case (r_scan_state)
        IDLE: begin
          r_scan_idx <= '0;
          if (w_tick) r_scan_state <= SCAN;
        end
        SCAN: begin
          if (r_scan_idx == IW'(CHANNELS - 1)) begin
            r_scan_state <= IDLE;
            r_scan_idx   <= '0;
          end else begin
            r_scan_idx <= r_scan_idx + IW'(1);
          end
        end
        default: r_scan_state <= IDLE;
      endcase
    end
  end

  // Single shared comparator: only the channel under the scan pointer is examined each clock.
  always_comb begin
    w_raw = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_scan_idx == IW'(k)) w_raw = rawValues[k*WIDTH +: WIDTH];
    end
    w_hist_eq = (w_raw == r_h1[r_scan_idx]) && (r_h1[r_scan_idx] == r_h2[r_scan_idx]) &&
                (r_h2[r_scan_idx] == r_h3[r_scan_idx]);
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_pending[k]  = (r_ch_state[k] == PENDING);
      stableMask[k] = (r_ch_state[k] != UNSTABLE);
    end
  end

  // The accept is written last so it overrides a same-clock visit to the granted channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_ch_state[k] <= UNSTABLE;
        r_h1[k]       <= '0;
        r_h2[k]       <= '0;
        r_h3[k]       <= '0;
        r_stable[k]   <= '0;
        r_fill[k]     <= '0;
      end
    end else begin
      if (w_visit) begin
        case (r_ch_state[r_scan_idx])
          UNSTABLE: begin
            r_h1[r_scan_idx] <= w_raw;
            r_h2[r_scan_idx] <= r_h1[r_scan_idx];
            r_h3[r_scan_idx] <= r_h2[r_scan_idx];
            if (r_fill[r_scan_idx] != 2'd3) r_fill[r_scan_idx] <= r_fill[r_scan_idx] + 2'd1;
            if (r_fill[r_scan_idx] == 2'd3 && w_hist_eq) begin
              r_stable[r_scan_idx]   <= w_raw;
              r_ch_state[r_scan_idx] <= PENDING;
            end
          end
          WAIT_UNSTABLE: begin
            if (w_raw != r_stable[r_scan_idx]) begin
              r_ch_state[r_scan_idx] <= UNSTABLE;
              r_h1[r_scan_idx]       <= w_raw;
              r_fill[r_scan_idx]     <= 2'd1;
            end
          end
          default: ;
        endcase
      end
      if (w_accept) r_ch_state[r_evt_ch] <= WAIT_UNSTABLE;
    end
  end

  stable_value_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arbiter (
    .i_req_mask    (w_pending),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_grant),
    .o_any_request (w_any_req)
  );

  // Arbitration only runs while nothing is presented, which yields the post-accept bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_vld    <= 1'b0;
      r_evt_ch     <= '0;
      r_evt_val    <= '0;
      r_last_grant <= IW'(CHANNELS - 1);
    end else if (!r_evt_vld) begin
      if (w_any_req) begin
        r_evt_vld <= 1'b1;
        r_evt_ch  <= w_grant;
        r_evt_val <= r_stable[w_grant];
      end
    end else if (eventReady) begin
      r_evt_vld    <= 1'b0;
      r_last_grant <= r_evt_ch;
    end
  end

  assign eventValid   = r_evt_vld;
  assign eventChannel = r_evt_ch;
  assign eventValue   = r_evt_val;

endmodule

// File: tb/tb_stable_value_scheduler.sv
// Bench for stable_value_scheduler (4 channels x 2 bits, tick every 8 clocks) against a
// run-length reference model of the debounce and round-robin event rules.
module tb_stable_value_scheduler;

  localparam int CH  = 4;
  localparam int W   = 2;
  localparam int DIV = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CH*W-1:0] rawValues;
  logic          eventValid;
  logic [1:0]    eventChannel;
  logic [W-1:0]  eventValue;
  logic          eventReady;
  logic [CH-1:0] stableMask;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  stable_value_scheduler #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DIVIDER  (DIV)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rawValues    (rawValues),
    .eventValid   (eventValid),
    .eventChannel (eventChannel),
    .eventValue   (eventValue),
    .eventReady   (eventReady),
    .stableMask   (stableMask)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: channel state 0=unstable 1=pending 2=waiting for change.
  int         m_n;
  int         m_st   [CH];
  int         m_run  [CH];
  logic [W-1:0] m_last [CH];
  logic [W-1:0] m_sv   [CH];
  bit         m_vld;
  int         m_ch;
  logic [W-1:0] m_val;
  int         m_lg;

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < CH; i++) begin
      m_st[i] = 0; m_run[i] = 0; m_last[i] = '0; m_sv[i] = '0;
    end
    m_vld = 1'b0; m_ch = 0; m_val = '0; m_lg = CH - 1;
  endtask

  task automatic model_step();
    bit           pmask [CH];
    int           k;
    int           c;
    logic [W-1:0] s;
    bit           acc;
    for (int i = 0; i < CH; i++) pmask[i] = (m_st[i] == 1);
    m_n++;
    acc = m_vld && (eventReady === 1'b1);
    // Channel k is sampled k+1 clocks after each prescaler tick.
    if (m_n > DIV && ((m_n - 1) % DIV) < CH) begin
      k = (m_n - 1) % DIV;
      s = rawValues[k*W +: W];
      if (m_st[k] == 0) begin
        if (m_run[k] > 0 && s == m_last[k]) m_run[k]++;
        else m_run[k] = 1;
        m_last[k] = s;
        if (m_run[k] >= 4) begin
          m_st[k] = 1;
          m_sv[k] = s;
        end
      end else if (m_st[k] == 2 && s != m_sv[k]) begin
        m_st[k] = 0; m_last[k] = s; m_run[k] = 1;
      end
    end
    if (acc) begin
      m_st[m_ch] = 2; m_lg = m_ch; m_vld = 1'b0;
    end else if (!m_vld) begin
      for (int i = 1; i <= CH; i++) begin
        c = (m_lg + i) % CH;
        if (!m_vld && pmask[c]) begin
          m_vld = 1'b1; m_ch = c; m_val = m_sv[c];
        end
      end
    end
  endtask

  function automatic logic [CH-1:0] model_mask();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = (m_st[i] != 0);
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    check_eq("valid", 32'(eventValid), 32'(m_vld));
    if (m_vld) begin
      check_eq("channel", 32'(eventChannel), 32'(m_ch));
      check_eq("value", 32'(eventValue), 32'(m_val));
    end
    check_eq("mask", 32'(stableMask), 32'(model_mask()));
  end

  // Stimulus: noisy channels flip between 01 and 10 on every tick so they never settle.
  logic [W-1:0] chv   [CH];
  bit           noisy [CH];

  task automatic apply();
    for (int k = 0; k < CH; k++) begin
      if (noisy[k]) chv[k] = (((m_n / DIV) % 2) != 0) ? 2'b01 : 2'b10;
    end
    rawValues = {chv[3], chv[2], chv[1], chv[0]};
  endtask

  task automatic step();
    @(negedge clock);
    apply();
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(eventValid), 32'd0);
    check_eq("rst_channel", 32'(eventChannel), 32'd0);
    check_eq("rst_value", 32'(eventValue), 32'd0);
    check_eq("rst_mask", 32'(stableMask), 32'd0);
    repeat (2) @(negedge clock);
    apply();
    #2 reset_n = 1'b1;
  endtask

  task automatic wait_evt(input int budget, output int cyc);
    cyc = 0;
    while (eventValid !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    check_eq("evt_seen", 32'(eventValid), 32'd1);
  endtask

  initial begin
    int cyc;
    int cnt;
    reset_n    = 1'b0;
    eventReady = 1'b0;
    rawValues  = '0;
    for (int k = 0; k < CH; k++) begin
      chv[k] = '0; noisy[k] = 1'b0;
    end

    // Single stable channel, consumer always ready.
    noisy = '{1'b1, 1'b1, 1'b0, 1'b1};
    chv[2] = 2'b10;
    eventReady = 1'b1;
    do_reset();
    wait_evt(100, cyc);
    check_eq("single_latency", 32'(cyc), 32'd36);
    check_eq("single_channel", 32'(eventChannel), 32'd2);
    check_eq("single_value", 32'(eventValue), 32'h2);
    check_eq("single_mask", 32'(stableMask), 32'h4);
    step();
    check_eq("single_accepted", 32'(eventValid), 32'd0);
    check_eq("single_wait_mask", 32'(stableMask), 32'h4);

    // Re-arm: unchanged for 50 ticks, then a new value.
    cnt = 0;
    repeat (50 * DIV) begin
      step();
      cnt += int'(eventValid);
    end
    check_eq("rearm_quiet", 32'(cnt), 32'd0);
    chv[2] = 2'b01;
    apply();
    wait_evt(100, cyc);
    check_eq("rearm_latency", 32'(cyc), 32'd31);
    check_eq("rearm_channel", 32'(eventChannel), 32'd2);
    check_eq("rearm_value", 32'(eventValue), 32'h1);

    // Contention between channels 0 and 3 under backpressure.
    noisy = '{1'b0, 1'b1, 1'b1, 1'b0};
    chv[0] = 2'b11;
    chv[3] = 2'b10;
    eventReady = 1'b0;
    do_reset();
    wait_evt(100, cyc);
    check_eq("cont_latency", 32'(cyc), 32'd34);
    check_eq("cont_first_ch", 32'(eventChannel), 32'd0);
    check_eq("cont_first_val", 32'(eventValue), 32'h3);
    for (int i = 0; i < 19; i++) begin
      step();
      check_eq("hold_valid", 32'(eventValid), 32'd1);
      check_eq("hold_channel", 32'(eventChannel), 32'd0);
    end
    eventReady = 1'b1;
    step();
    eventReady = 1'b0;
    check_eq("bubble", 32'(eventValid), 32'd0);
    step();
    check_eq("second_valid", 32'(eventValid), 32'd1);
    check_eq("second_channel", 32'(eventChannel), 32'd3);
    check_eq("second_value", 32'(eventValue), 32'h2);

    // Reset while channel 3 is presented; channel 0 must rebuild its history from scratch.
    noisy = '{1'b0, 1'b1, 1'b1, 1'b1};
    eventReady = 1'b1;
    do_reset();
    wait_evt(100, cyc);
    check_eq("post_reset_latency", 32'(cyc), 32'd34);
    check_eq("post_reset_channel", 32'(eventChannel), 32'd0);

    // Bounce on channel 1, then a steady level.
    cnt = 0;
    repeat (60) begin
      step();
      cnt += int'(eventValid);
    end
    check_eq("bounce_quiet", 32'(cnt), 32'd0);
    noisy[1] = 1'b0;
    chv[1] = 2'b01;
    apply();
    wait_evt(100, cyc);
    check_eq("bounce_channel", 32'(eventChannel), 32'd1);
    check_eq("bounce_value", 32'(eventValue), 32'h1);

    // Random slowly-changing inputs and random ready, with one reset in the middle.
    noisy = '{1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 24) == 0) chv[k] = W'($urandom);
      end
      if (i == 1500) do_reset();
      step();
      eventReady = 1'($urandom_range(0, 1));
      cnt += int'(eventValid);
    end
    check_eq("random_events_seen", 32'(cnt > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
